// File: rtl/systolic_pkg.sv
// Shared definitions for the N x N systolic matrix-multiply block.
package systolic_pkg;

    localparam int unsigned DefaultN  = 4;
    localparam int unsigned DefaultDw = 8;
    localparam int unsigned DefaultAw = 32;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StCompute,
        StOut
    } state_e;

endpackage

// File: rtl/systolic_pe_param.sv
// Processing element: forwards A east and B south, multiply-accumulates locally.
module systolic_pe_param
    import systolic_pkg::*;
#(
    parameter int unsigned DW = DefaultDw,
    parameter int unsigned AW = DefaultAw
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clr,
    input  logic                 en,
    input  logic signed [DW-1:0] a_in,
    input  logic signed [DW-1:0] b_in,
    output logic signed [DW-1:0] a_out,
    output logic signed [DW-1:0] b_out,
    output logic signed [AW-1:0] acc
);

    logic signed [2*DW-1:0] prod;
    logic signed [AW-1:0]   acc_d;

    assign prod = a_in * b_in;

    // Clearing still folds in this cycle's product so the first wavefront is not lost.
    always_comb begin
        acc_d = (clr ? '0 : acc) + AW'(prod);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_out <= '0;
            b_out <= '0;
            acc   <= '0;
        end else if (en) begin
            a_out <= a_in;
            b_out <= b_in;
            acc   <= acc_d;
        end
    end

endmodule

// File: rtl/systolic_array_nxn.sv
// N x N output-stationary systolic multiplier: loads A rows and B columns,
// streams skewed operands through the mesh, then emits C one row per beat.
module systolic_array_nxn
    import systolic_pkg::*;
#(
    parameter int unsigned N  = DefaultN,
    parameter int unsigned DW = DefaultDw,
    parameter int unsigned AW = DefaultAw
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          acc_mode,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N*DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N*AW-1:0] out_data,
    output logic          out_last,
    output logic          busy,
    output logic          done
);

    localparam int unsigned BW = $clog2(2 * N);
    localparam int unsigned CW = $clog2(3 * N);
    localparam int unsigned RW = $clog2(N);
    localparam logic [BW-1:0] LastBeat = BW'(2 * N - 1);
    localparam logic [BW-1:0] BeatN    = BW'(N);
    localparam logic [CW-1:0] LastCyc  = CW'(3 * N - 2);
    localparam logic [RW-1:0] LastRow  = RW'(N - 1);

    state_e          state_q, state_d;
    logic [BW-1:0]   beat_q;
    logic [CW-1:0]   cyc_q;
    logic [RW-1:0]   row_q;
    logic            acc_mode_q;
    logic            in_fire, out_fire, load_b, clr, en;
    logic [RW-1:0]   beat_idx;

    logic signed [DW-1:0] a_mem [N][N];
    logic signed [DW-1:0] b_mem [N][N];
    logic signed [DW-1:0] a_west [N];
    logic signed [DW-1:0] b_north [N];
    logic signed [DW-1:0] a_pipe [N][N];
    logic signed [DW-1:0] b_pipe [N][N];
    logic signed [AW-1:0] acc_m [N][N];
    logic signed [DW-1:0] unused_a_east [N];
    logic signed [DW-1:0] unused_b_south [N];

    assign in_ready  = (state_q == StIdle) || (state_q == StLoad);
    assign in_fire   = in_valid && in_ready;
    assign out_valid = (state_q == StOut);
    assign out_fire  = out_valid && out_ready;
    assign out_last  = out_valid && (row_q == LastRow);
    assign done      = out_fire && (row_q == LastRow);
    assign busy      = (state_q != StIdle);
    assign en        = (state_q == StCompute);
    assign clr       = en && (cyc_q == '0) && !acc_mode_q;
    assign load_b    = (beat_q >= BeatN);
    assign beat_idx  = load_b ? RW'(beat_q - BeatN) : RW'(beat_q);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (in_fire) state_d = StLoad;
            StLoad:    if (in_fire && beat_q == LastBeat) state_d = StCompute;
            StCompute: if (cyc_q == LastCyc) state_d = StOut;
            StOut:     if (done) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            beat_q     <= '0;
            cyc_q      <= '0;
            row_q      <= '0;
            acc_mode_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (in_fire) beat_q <= (beat_q == LastBeat) ? '0 : beat_q + 1'b1;
            if (state_q == StIdle && in_fire) acc_mode_q <= acc_mode;
            if (en) cyc_q <= (cyc_q == LastCyc) ? '0 : cyc_q + 1'b1;
            if (out_fire) row_q <= (row_q == LastRow) ? '0 : row_q + 1'b1;
        end
    end

    // Operand store; contents are only meaningful once a full job is loaded.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            for (int l = 0; l < N; l++) begin
                if (load_b) b_mem[l][beat_idx] <= in_data[l*DW +: DW];
                else        a_mem[beat_idx][l] <= in_data[l*DW +: DW];
            end
        end
    end

    // Skewed injection: element k enters row/column i on compute cycle i + k.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            a_west[i]  = '0;
            b_north[i] = '0;
            for (int k = 0; k < N; k++) begin
                if (int'(cyc_q) == i + k) begin
                    a_west[i]  = a_mem[i][k];
                    b_north[i] = b_mem[k][i];
                end
            end
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            logic signed [DW-1:0] a_in, b_in;
            if (j == 0) begin : g_west
                assign a_in = a_west[i];
            end else begin : g_inner_a
                assign a_in = a_pipe[i][j-1];
            end
            if (i == 0) begin : g_north
                assign b_in = b_north[j];
            end else begin : g_inner_b
                assign b_in = b_pipe[i-1][j];
            end
            systolic_pe_param #(
                .DW(DW),
                .AW(AW)
            ) u_pe (
                .clk  (clk),
                .reset(reset),
                .clr  (clr),
                .en   (en),
                .a_in (a_in),
                .b_in (b_in),
                .a_out(a_pipe[i][j]),
                .b_out(b_pipe[i][j]),
                .acc  (acc_m[i][j])
            );
        end
        assign unused_a_east[i]  = a_pipe[i][N-1];
        assign unused_b_south[i] = b_pipe[N-1][i];
    end

    always_comb begin
        out_data = '0;
        if (state_q == StOut) begin
            for (int j = 0; j < N; j++) out_data[j*AW +: AW] = acc_m[row_q][j];
        end
    end

endmodule
